alu_bist: RTL and testbench

Built-in self-test engine for the 4-bit ALU (ADD, SUB, NAND, XOR, signed-overflow `Error`). It exhaustively drives all 1024 `{opcode, in1, in2}` combinations into an ALU instance and checks every response against an internal reference model. It then reports pass/fail, a mismatch count and the first failing vector. It sits beside the ALU and is the synthesizable checking end of the ALU interface, used at power-on and on demand.

---
 rtl/alu_bist.sv | 109 ++++++++++
 tb/tb_alu_bist.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_bist.sv
// alu_bist: exhaustive self-test of the 4-bit ALU over all {opcode, in1, in2} vectors
module alu_bist #(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [3:0]  alu_in1,
  output logic [3:0]  alu_in2,
  output logic [1:0]  alu_opcode,
  input  logic [3:0]  alu_out,
  input  logic        alu_error,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [10:0] fail_count,
  output logic [9:0]  first_fail_vec,
  output logic        first_fail_valid
);
  localparam int HW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;
  state_t state;
  logic [9:0] idx;
  logic [HW-1:0] hold;
  logic drive;
  logic chk, chk_last, chk_err, chk_eerr;
  logic [9:0] chk_vec;
  logic [3:0] chk_out, chk_r;
  logic [3:0] a, b, sum, dif, ref_r;
  logic ref_e, hold_last, mismatch;
  assign alu_opcode = idx[9:8];
  assign alu_in1 = idx[7:4];
  assign alu_in2 = idx[3:0];
  assign a = idx[7:4];
  assign b = idx[3:0];
  assign sum = a + b;
  assign dif = a - b;
  assign hold_last = hold == HW'(SETTLE - 1);
  assign mismatch = chk && (chk_r != chk_out || chk_eerr != chk_err);
  always_comb begin
    ref_r = idx[9] ? (idx[8] ? a ^ b : ~(a & b)) : (idx[8] ? dif : sum);
    ref_e = idx[9] ? 1'b0 :
            idx[8] ? (a[3] != b[3]) && (dif[3] != a[3]) :
                     (a[3] == b[3]) && (sum[3] != a[3]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx <= '0;
      hold <= '0;
      drive <= 1'b0;
      chk <= 1'b0;
      chk_last <= 1'b0;
      chk_err <= 1'b0;
      chk_eerr <= 1'b0;
      chk_vec <= '0;
      chk_out <= '0;
      chk_r <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      fail_count <= '0;
      first_fail_vec <= '0;
      first_fail_valid <= 1'b0;
    end else if (state == S_RUN) begin
      chk <= drive && hold_last;
      if (drive && hold_last) begin
        chk_vec <= idx;
        chk_out <= alu_out;
        chk_err <= alu_error;
        chk_r <= ref_r;
        chk_eerr <= ref_e;
        chk_last <= &idx;
        hold <= '0;
        if (&idx) drive <= 1'b0;
        else idx <= idx + 10'd1;
      end else if (drive) begin
        hold <= hold + 1'b1;
      end
      if (mismatch) begin
        fail_count <= fail_count + 11'd1;
        if (!first_fail_valid) begin
          first_fail_vec <= chk_vec;
          first_fail_valid <= 1'b1;
        end
      end
      // last check: fold this cycle's mismatch into the verdict
      if (chk && chk_last) begin
        state <= S_FIN;
        busy <= 1'b0;
        done <= 1'b1;
        pass <= fail_count == 0 && !mismatch;
      end
    end else if (start) begin
      state <= S_RUN;
      idx <= '0;
      hold <= '0;
      drive <= 1'b1;
      chk <= 1'b0;
      chk_last <= 1'b0;
      busy <= 1'b1;
      done <= 1'b0;
      pass <= 1'b0;
      fail_count <= '0;
      first_fail_vec <= '0;
      first_fail_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_bist.sv
// tb_alu_bist: directed bench for alu_bist with a fault-injectable ALU model
module tb_alu_bist;
  logic clk = 0;
  logic rst_n = 0;
  logic start1 = 0, start3 = 0;
  int fault1 = 0, fault3 = 0;
  int total = 0, bad = 0;
  logic [3:0] in1_1, in2_1, out1, in1_3, in2_3, out3;
  logic [1:0] op1, op3;
  logic err1, err3;
  logic busy1, done1, pass1, ffv1, busy3, done3, pass3, ffv3;
  logic [10:0] fc1, fc3;
  logic [9:0] fvec1, fvec3;

  always #5 clk = ~clk;

  function automatic logic [4:0] alu_model(input logic [1:0] op, input logic [3:0] x, input logic [3:0] y, input int fault);
    logic [3:0] r;
    logic e;
    case (op)
      2'd0: begin r = x + y; e = (x[3] == y[3]) && (r[3] != x[3]); end
      2'd1: begin r = x - y; e = (x[3] != y[3]) && (r[3] != x[3]); end
      2'd2: begin r = (fault == 2) ? (x & y) : ~(x & y); e = 1'b0; end
      default: begin r = x ^ y; e = 1'b0; end
    endcase
    if (fault == 1) e = 1'b0;
    return {e, r};
  endfunction

  always_comb {err1, out1} = alu_model(op1, in1_1, in2_1, fault1);
  always_comb {err3, out3} = alu_model(op3, in1_3, in2_3, fault3);

  alu_bist #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .alu_in1(in1_1), .alu_in2(in2_1), .alu_opcode(op1),
    .alu_out(out1), .alu_error(err1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_count(fc1),
    .first_fail_vec(fvec1), .first_fail_valid(ffv1)
  );

  alu_bist #(.SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3),
    .alu_in1(in1_3), .alu_in2(in2_3), .alu_opcode(op3),
    .alu_out(out3), .alu_error(err3),
    .busy(busy3), .done(done3), .pass(pass3), .fail_count(fc3),
    .first_fail_vec(fvec3), .first_fail_valid(ffv3)
  );

  task automatic pulse1();
    @(negedge clk) start1 = 1;
    @(posedge clk);
    @(negedge clk) start1 = 0;
  endtask

  // counts edges after the start edge until done; pokes start at poke_at if nonzero
  task automatic wait_done1(input int poke_at, output int n);
    logic both = 0;
    n = 0;
    while (n < 5000) begin
      @(posedge clk);
      n++;
      #1;
      start1 = (poke_at != 0) && (n == poke_at - 1);
      if (busy1 && done1) both = 1;
      if (done1) break;
    end
    start1 = 0;
    total++;
    if (both) begin bad++; $display("FAIL busy_done_overlap busy and done both high"); end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    total++; if ({busy1, done1, pass1} !== 3'b000) begin bad++; $display("FAIL reset_flags got %b want 000", {busy1, done1, pass1}); end
    total++; if (fc1 !== 11'd0) begin bad++; $display("FAIL reset_count got %0d want 0", fc1); end
    total++; if ({fvec1, ffv1} !== 11'd0) begin bad++; $display("FAIL reset_first got %h/%b want 0/0", fvec1, ffv1); end
    total++; if ({op1, in1_1, in2_1} !== 10'd0) begin bad++; $display("FAIL reset_drive got %h want 0", {op1, in1_1, in2_1}); end
    @(negedge clk) rst_n = 1;
  endtask

  task automatic test_pass();
    int n;
    fault1 = 0;
    @(negedge clk) start1 = 1;
    @(posedge clk);
    #1;
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL start_busy got %b want 1", busy1); end
    @(negedge clk) start1 = 0;
    wait_done1(0, n);
    total++; if (n !== 1025) begin bad++; $display("FAIL pass_latency got %0d want 1025", n); end
    total++; if ({done1, pass1, busy1} !== 3'b110) begin bad++; $display("FAIL pass_flags got %b want 110", {done1, pass1, busy1}); end
    total++; if (fc1 !== 11'd0) begin bad++; $display("FAIL pass_count got %0d want 0", fc1); end
    total++; if (ffv1 !== 1'b0) begin bad++; $display("FAIL pass_ffv got %b want 0", ffv1); end
  endtask

  task automatic test_err_stuck();
    int n;
    fault1 = 1;
    pulse1();
    wait_done1(0, n);
    total++; if (n !== 1025) begin bad++; $display("FAIL err_latency got %0d want 1025", n); end
    total++; if (fc1 !== 11'd128) begin bad++; $display("FAIL err_count got %0d want 128", fc1); end
    total++; if (pass1 !== 1'b0) begin bad++; $display("FAIL err_pass got %b want 0", pass1); end
    total++; if ({ffv1, fvec1} !== {1'b1, 10'h017}) begin bad++; $display("FAIL err_first got %b/%h want 1/017", ffv1, fvec1); end
  endtask

  task automatic test_nand_fault();
    int n;
    fault1 = 2;
    pulse1();
    wait_done1(0, n);
    total++; if (fc1 !== 11'd256) begin bad++; $display("FAIL nand_count got %0d want 256", fc1); end
    total++; if ({ffv1, fvec1} !== {1'b1, 10'h200}) begin bad++; $display("FAIL nand_first got %b/%h want 1/200", ffv1, fvec1); end
    total++; if (pass1 !== 1'b0) begin bad++; $display("FAIL nand_pass got %b want 0", pass1); end
  endtask

  task automatic test_settle3();
    int n = 0;
    logic [9:0] want;
    fault3 = 0;
    @(negedge clk) start3 = 1;
    @(posedge clk);
    @(negedge clk) start3 = 0;
    while (n < 10000) begin
      @(posedge clk);
      n++;
      #1;
      if (n >= 14 && n <= 18) begin
        want = (n == 14) ? 10'h004 : (n == 18) ? 10'h006 : 10'h005;
        total++;
        if ({op3, in1_3, in2_3} !== want) begin bad++; $display("FAIL settle_hold cycle %0d got %h want %h", n, {op3, in1_3, in2_3}, want); end
      end
      if (done3) break;
    end
    total++; if (n !== 3073) begin bad++; $display("FAIL settle_latency got %0d want 3073", n); end
    total++; if ({pass3, fc3} !== {1'b1, 11'd0}) begin bad++; $display("FAIL settle_result got %b/%0d want 1/0", pass3, fc3); end
  endtask

  task automatic test_mid_reset();
    int n;
    fault1 = 1;
    pulse1();
    repeat (399) @(posedge clk);
    #1;
    total++; if (fc1 == 11'd0 || busy1 !== 1'b1) begin bad++; $display("FAIL midrun_progress got count %0d busy %b want nonzero/1", fc1, busy1); end
    #1 rst_n = 0;
    #1;
    total++; if ({busy1, done1, pass1, ffv1} !== 4'b0000) begin bad++; $display("FAIL async_flags got %b want 0000", {busy1, done1, pass1, ffv1}); end
    total++; if ({fc1, fvec1, op1, in1_1, in2_1} !== 31'd0) begin bad++; $display("FAIL async_values got %h want 0", {fc1, fvec1, op1, in1_1, in2_1}); end
    @(negedge clk) rst_n = 1;
    repeat (3) @(posedge clk);
    #1;
    total++; if ({busy1, done1} !== 2'b00) begin bad++; $display("FAIL post_reset_idle got %b want 00", {busy1, done1}); end
    pulse1();
    wait_done1(0, n);
    total++; if ({n, fc1} !== {32'd1025, 11'd128}) begin bad++; $display("FAIL rerun got cyc %0d count %0d want 1025/128", n, fc1); end
  endtask

  task automatic test_back_to_back();
    int n;
    fault1 = 0;
    pulse1();
    wait_done1(200, n);
    total++; if (n !== 1025) begin bad++; $display("FAIL ignore_start got %0d want 1025", n); end
    @(negedge clk) start1 = 1;
    @(posedge clk);
    #1;
    total++; if ({done1, busy1} !== 2'b01) begin bad++; $display("FAIL restart_flags got %b want 01", {done1, busy1}); end
    @(negedge clk) start1 = 0;
    wait_done1(0, n);
    total++; if ({n, pass1} !== {32'd1025, 1'b1}) begin bad++; $display("FAIL restart_run got cyc %0d pass %b want 1025/1", n, pass1); end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_err_stuck();
    test_nand_fault();
    test_settle3();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
